proc_alu: RTL and testbench
===========================

# proc_alu

8-bit registered arithmetic/logic unit of the s_proc datapath. Each cycle it takes two 8-bit operands and a 5-bit operation code, computes the result, and registers the result plus a persistent carry flag and a zero flag. The registered carry feeds back as carry-in for the carry-chained operations ADC and SBC. It sits between the register-file read ports and the write-back mux.

## Interface
Parameters: none; the datapath width is fixed at 8 bits.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  8  operand A
- b  input  8  operand B
- alu  input  5  operation code
- dout  output  8  registered result
- carry  output  1  registered carry/borrow flag; also the carry-in for ADC/SBC
- zero  output  1  registered; 1 when the dout value registered at that edge is 0x00

One clock; reset is asynchronous and active-low.

## Operation
Opcode map, with C = current carry register:
- 00000 ADD: {carry,dout} = a+b
- 00001 SUB: dout = a-b; carry = 1 if a<b (borrow)
- 00010 ADC: {carry,dout} = a+b+C
- 00011 SBC: dout = a-b-C; carry = 1 if a < b+C
- 00100 INC: dout = a+1; carry = (a==0xFF)
- 00101 DEC: dout = a-1; carry = (a==0x00)
- 01000 PASSA: dout = a; carry = 0
- 01001 PASSB: dout = b; carry = 0
- 01100 AND: dout = a&b; carry = 0
- 01101 OR: dout = a|b; carry = 0
- 01110 XOR: dout = a^b; carry = 0
- 01111 NOT: dout = ~a; carry = 0
- 10000 SHL: dout = {a[6:0],0}; carry = a[7]
- 10001 SHR: dout = {0,a[7:1]}; carry = a[0]
- 10010 ASR: dout = {a[7],a[7:1]}; carry = a[0]
- 10011 ROL: dout = {a[6:0],a[7]}; carry = a[7]
- 10100 ROR: dout = {a[0],a[7:1]}; carry = a[0]

Arithmetic rules:
- Arithmetic is modulo 256; sums are computed 9 bits wide, and bit 8 is the carry.
- Every other opcode is illegal: dout is set to 0x00, zero is set to 1, and carry holds its value.
- zero is always derived from the next dout value, including for illegal opcodes.

## Timing
- Reset: dout = 0x00, carry = 0, zero = 0, applied immediately on rst_n low, independent of clk.
- Latency is one cycle. Operands and opcode are sampled at a rising edge, and results are visible after that edge. There is no enable and no handshake; an operation executes every cycle.
- ADC/SBC use the carry value registered at the previous edge. Back-to-back chained operations therefore work at one operation per cycle.
- When reset is asserted mid-sequence, the pending result is discarded and carry is cleared. The first edge after rst_n rises computes from the operands present at that edge, with C = 0.
- Operand or opcode changes between edges have no effect on the outputs.

## Configuration
- ALU_SHIFT_EN defined: the shift/rotate group (10000–10100) is implemented as specified above.
- ALU_SHIFT_EN undefined: opcodes 10000–10100 behave as illegal opcodes (dout = 0x00, zero = 1, carry held), and no shifter logic is synthesised.

## Test plan
- Reset, then a=0x05, b=0x07, alu=00000 (ADD) -> dout 0x0C, carry 0, zero 0 after one edge.
- Same operands, alu=01100 (AND) -> dout 0x05, carry 0.
- Same operands, alu=00001 (SUB) -> dout 0xFE, carry 1; next cycle alu=00010 (ADC) -> dout 0x0D, carry 0.
- a=0xFF, b=0x01, ADD -> dout 0x00, carry 1, zero 1; next cycle alu=11111 (illegal) -> dout 0x00, zero 1, carry stays 1.
- With ALU_SHIFT_EN, a=0x81: SHL -> dout 0x02, carry 1; ROR -> dout 0xC0, carry 1. Without ALU_SHIFT_EN, SHL -> dout 0x00, carry unchanged.
- Pull rst_n low between edges while carry = 1 -> dout, carry and zero clear immediately without a clock edge. After release, ADC with a=0x01, b=0x01 -> dout 0x02.

Source files
------------

// File: rtl/proc_alu.sv
// 8-bit registered ALU with persistent carry feeding ADC/SBC.
// Define ALU_SHIFT_EN to build the shift/rotate group; otherwise those opcodes are illegal.
module proc_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] alu,
  output logic [7:0] dout,
  output logic       carry,
  output logic       zero
);

  localparam int unsigned W = 8;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_ADC   = 5'b00010;
  localparam logic [4:0] OP_SBC   = 5'b00011;
  localparam logic [4:0] OP_INC   = 5'b00100;
  localparam logic [4:0] OP_DEC   = 5'b00101;
  localparam logic [4:0] OP_PASSA = 5'b01000;
  localparam logic [4:0] OP_PASSB = 5'b01001;
  localparam logic [4:0] OP_AND   = 5'b01100;
  localparam logic [4:0] OP_OR    = 5'b01101;
  localparam logic [4:0] OP_XOR   = 5'b01110;
  localparam logic [4:0] OP_NOT   = 5'b01111;
`ifdef ALU_SHIFT_EN
  localparam logic [4:0] OP_SHL   = 5'b10000;
  localparam logic [4:0] OP_SHR   = 5'b10001;
  localparam logic [4:0] OP_ASR   = 5'b10010;
  localparam logic [4:0] OP_ROL   = 5'b10011;
  localparam logic [4:0] OP_ROR   = 5'b10100;
`endif

  logic [W-1:0] dout_nxt;
  logic         carry_nxt;

  // Next result and carry; bit W of the 9-bit sum/difference is carry or borrow.
  always_comb begin
    dout_nxt  = '0;
    carry_nxt = carry;
    case (alu)
      OP_ADD:   {carry_nxt, dout_nxt} = {1'b0, a} + {1'b0, b};
      OP_SUB:   {carry_nxt, dout_nxt} = {1'b0, a} - {1'b0, b};
      OP_ADC:   {carry_nxt, dout_nxt} = {1'b0, a} + {1'b0, b} + (W+1)'(carry);
      OP_SBC:   {carry_nxt, dout_nxt} = {1'b0, a} - {1'b0, b} - (W+1)'(carry);
      OP_INC:   {carry_nxt, dout_nxt} = {1'b0, a} + (W+1)'(1);
      OP_DEC:   {carry_nxt, dout_nxt} = {1'b0, a} - (W+1)'(1);
      OP_PASSA: begin dout_nxt = a;     carry_nxt = 1'b0; end
      OP_PASSB: begin dout_nxt = b;     carry_nxt = 1'b0; end
      OP_AND:   begin dout_nxt = a & b; carry_nxt = 1'b0; end
      OP_OR:    begin dout_nxt = a | b; carry_nxt = 1'b0; end
      OP_XOR:   begin dout_nxt = a ^ b; carry_nxt = 1'b0; end
      OP_NOT:   begin dout_nxt = ~a;    carry_nxt = 1'b0; end
`ifdef ALU_SHIFT_EN
      OP_SHL:   begin dout_nxt = {a[W-2:0], 1'b0};   carry_nxt = a[W-1]; end
      OP_SHR:   begin dout_nxt = {1'b0, a[W-1:1]};   carry_nxt = a[0];   end
      OP_ASR:   begin dout_nxt = {a[W-1], a[W-1:1]}; carry_nxt = a[0];   end
      OP_ROL:   begin dout_nxt = {a[W-2:0], a[W-1]}; carry_nxt = a[W-1]; end
      OP_ROR:   begin dout_nxt = {a[0], a[W-1:1]};   carry_nxt = a[0];   end
`endif
      default: begin
        dout_nxt  = '0;
        carry_nxt = carry;
      end
    endcase
  end

  // Result, carry and zero registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      dout  <= dout_nxt;
      carry <= carry_nxt;
      zero  <= (dout_nxt == '0);
    end
  end

endmodule

// File: tb/tb_proc_alu.sv
// Directed-vector bench for proc_alu; shift expectations follow ALU_SHIFT_EN.
module tb_proc_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] alu;
  logic [7:0] dout;
  logic       carry;
  logic       zero;

  int n_cmp = 0;
  int n_err = 0;

  proc_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .alu   (alu),
    .dout  (dout),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic [4:0] top);
    a   = ta;
    b   = tb;
    alu = top;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a = 8'h00; b = 8'h00; alu = 5'b00000;
    #1;
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got dout=%h c=%b z=%b want 00 0 0", dout, carry, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Vector table: {a, b, op, dout, carry, zero}, applied in order.
  task automatic test_arith_logic;
    logic [7:0] va [14];
    logic [7:0] vb [14];
    logic [4:0] vo [14];
    logic [9:0] ve [14];
    va = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h10, 8'hFF, 8'h00, 8'h05};
    vb = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00};
    vo = '{5'b00000, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b01000, 5'b01001,
           5'b00001, 5'b00010, 5'b00011, 5'b00011, 5'b00100, 5'b00101, 5'b00100};
    ve = '{{8'h0C, 2'b00}, {8'h05, 2'b00}, {8'h07, 2'b00}, {8'h02, 2'b00}, {8'hFA, 2'b00},
           {8'h05, 2'b00}, {8'h07, 2'b00}, {8'hFE, 2'b10}, {8'h0D, 2'b00}, {8'hFE, 2'b10},
           {8'h0E, 2'b00}, {8'h00, 2'b11}, {8'hFF, 2'b10}, {8'h06, 2'b00}};
    for (int i = 0; i < 14; i++) begin
      step(va[i], vb[i], vo[i]);
      n_cmp++;
      if ({dout, carry, zero} !== ve[i]) begin
        n_err++;
        $display("FAIL arith_logic[%0d] op=%b: got %h %b %b want %h %b %b",
                 i, vo[i], dout, carry, zero, ve[i][9:2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_illegal;
    step(8'hFF, 8'h01, 5'b00000);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL add_wrap: got %h %b %b want 00 1 1", dout, carry, zero);
    end
    step(8'h12, 8'h34, 5'b11111);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_hold1: got %h %b %b want 00 1 1", dout, carry, zero);
    end
    step(8'h05, 8'h00, 5'b01000);
    step(8'hAA, 8'h55, 5'b00110);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_hold0: got %h %b %b want 00 0 1", dout, carry, zero);
    end
  endtask

  task automatic test_shift;
    logic [4:0] so [5];
    logic [9:0] se [5];
    so = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100};
`ifdef ALU_SHIFT_EN
    se = '{{8'h02, 2'b10}, {8'h40, 2'b10}, {8'hC0, 2'b10}, {8'h03, 2'b10}, {8'hC0, 2'b10}};
`else
    se = '{{8'h00, 2'b11}, {8'h00, 2'b11}, {8'h00, 2'b11}, {8'h00, 2'b11}, {8'h00, 2'b11}};
`endif
    for (int i = 0; i < 5; i++) begin
      step(8'hFF, 8'h01, 5'b00000);
      step(8'h81, 8'h00, so[i]);
      n_cmp++;
      if ({dout, carry, zero} !== se[i]) begin
        n_err++;
        $display("FAIL shift[%0d] op=%b: got %h %b %b want %h %b %b",
                 i, so[i], dout, carry, zero, se[i][9:2], se[i][1], se[i][0]);
      end
    end
    // Shifting a value whose outgoing bit is 0 clears carry (or holds 0 when disabled).
    step(8'h00, 8'h00, 5'b01000);
    step(8'h42, 8'h00, 5'b10000);
    n_cmp++;
`ifdef ALU_SHIFT_EN
    if ({dout, carry, zero} !== {8'h84, 1'b0, 1'b0}) begin
`else
    if ({dout, carry, zero} !== {8'h00, 1'b0, 1'b1}) begin
`endif
      n_err++;
      $display("FAIL shl_nocarry: got %h %b %b", dout, carry, zero);
    end
  endtask

  task automatic test_back_to_back;
    // 16-bit add 0x12FF + 0x0001 as ADD then ADC.
    step(8'hFF, 8'h01, 5'b00000);
    step(8'h12, 8'h00, 5'b00010);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h13, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL chain_adc: got %h %b %b want 13 0 0", dout, carry, zero);
    end
    // 16-bit subtract 0x1000 - 0x0001 as SUB then SBC.
    step(8'h00, 8'h01, 5'b00001);
    step(8'h10, 8'h00, 5'b00011);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h0F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL chain_sbc: got %h %b %b want 0F 0 0", dout, carry, zero);
    end
    // SBC borrow boundary: a=0, b=0xFF, C=1 -> 0x00 with borrow.
    step(8'h00, 8'h01, 5'b00001);
    step(8'h00, 8'hFF, 5'b00011);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sbc_edge: got %h %b %b want 00 1 1", dout, carry, zero);
    end
  endtask

  task automatic test_async_reset;
    step(8'hFF, 8'h02, 5'b00000);
    // Inputs changing between edges must not disturb the outputs.
    a = 8'h00; b = 8'h00; alu = 5'b01111;
    #2;
    n_cmp++;
    if ({dout, carry, zero} !== {8'h01, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL between_edges: got %h %b %b want 01 1 0", dout, carry, zero);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dout, carry, zero} !== {8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %h %b %b want 00 0 0", dout, carry, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 8'h01, 5'b00010);
    n_cmp++;
    if ({dout, carry, zero} !== {8'h02, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_adc: got %h %b %b want 02 0 0", dout, carry, zero);
    end
  endtask

  initial begin
    test_reset;
    test_arith_logic;
    test_illegal;
    test_shift;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
